// File: rtl/accu_pkg.sv
// Shared defaults and constant helpers for the windowed accumulator.
package accu_pkg;

  localparam int DEF_IN_W    = 32;
  localparam int DEF_CH      = 4;
  localparam int DEF_MAX_LEN = 64;

  // Ceiling log2, usable in parameter and localparam expressions.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/accu_window_unit_if.sv
// Sample input and window-result output bundle of accu_window_unit.
interface accu_window_unit_if
  import accu_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int CH      = DEF_CH,
  parameter int MAX_LEN = DEF_MAX_LEN
) ();

  localparam int CNT_W = clog2(MAX_LEN + 1);
  localparam int OUT_W = IN_W + clog2(MAX_LEN);

  logic [CNT_W-1:0]    win_len;
  logic                in_valid;
  logic                in_ready;
  logic [CH*IN_W-1:0]  din;
  logic                out_valid;
  logic                out_ready;
  logic [CH*OUT_W-1:0] dout;
  logic [CNT_W-1:0]    out_len;

  modport master (
    output win_len, in_valid, din, out_ready,
    input  in_ready, out_valid, dout, out_len
  );

  modport slave (
    input  win_len, in_valid, din, out_ready,
    output in_ready, out_valid, dout, out_len
  );

endinterface

// File: rtl/accu_lane.sv
// One channel: signed running accumulator plus the register holding its last window sum.
module accu_lane
  import accu_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_IN_W + 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             accept,
  input  logic             last,
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  logic [OUT_W-1:0] acc_q;
  logic [OUT_W-1:0] acc_d;
  logic [OUT_W-1:0] dout_q;
  logic [OUT_W-1:0] dout_d;
  logic [OUT_W-1:0] sum_s;

  // Next accumulator and output register; the last sample goes straight into the result.
  always_comb begin
    acc_d  = acc_q;
    dout_d = dout_q;
    sum_s  = acc_q + {{(OUT_W-IN_W){din[IN_W-1]}}, din};
    if (clr) begin
      acc_d = {OUT_W{1'b0}};
    end else if (accept) begin
      if (last) begin
        dout_d = sum_s;
        acc_d  = {OUT_W{1'b0}};
      end else begin
        acc_d  = sum_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= {OUT_W{1'b0}};
      dout_q <= {OUT_W{1'b0}};
    end else begin
      acc_q  <= acc_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/accu_window_unit.sv
// Multi-channel windowed summer: sums win_len samples per channel and presents one result per window.
module accu_window_unit
  import accu_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int CH      = DEF_CH,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input logic               clk,
  input logic               rst_n,
  input logic               clr,
  accu_window_unit_if.slave bus
);

  localparam int CNT_W = clog2(MAX_LEN + 1);
  localparam int OUT_W = IN_W + clog2(MAX_LEN);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    out_len_q, out_len_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    len_in_s;
  logic [CNT_W-1:0]    len_eff_s;
  logic                last_pending_s;
  logic                in_ready_s;
  logic                accept_s;
  logic                pop_s;
  logic [CH*OUT_W-1:0] dout_s;

  // Clamp the requested length into 1..MAX_LEN.
  always_comb begin
    if (bus.win_len == CNT_W'(0)) begin
      len_in_s = CNT_W'(1);
    end else if (bus.win_len > CNT_W'(MAX_LEN)) begin
      len_in_s = CNT_W'(MAX_LEN);
    end else begin
      len_in_s = bus.win_len;
    end
  end

  // At counter 0 the window has not started, so win_len (not len_q) governs the first sample.
  always_comb begin
    len_eff_s      = (cnt_q == CNT_W'(0)) ? len_in_s : len_q;
    last_pending_s = (cnt_q == (len_eff_s - CNT_W'(1)));
    in_ready_s     = !(last_pending_s && out_valid_q && !bus.out_ready);
    accept_s       = bus.in_valid && in_ready_s;
    pop_s          = out_valid_q && bus.out_ready;
  end

  // Counter, latched length and result handshake; clr outranks accept and pop.
  always_comb begin
    cnt_d       = cnt_q;
    len_d       = len_q;
    out_len_d   = out_len_q;
    out_valid_d = out_valid_q;
    if (clr) begin
      cnt_d       = CNT_W'(0);
      out_valid_d = 1'b0;
    end else begin
      if (pop_s) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
      if (accept_s) begin
        len_d = len_eff_s;
        if (last_pending_s) begin
          cnt_d       = CNT_W'(0);
          out_valid_d = 1'b1;
          out_len_d   = len_eff_s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // Control registers; len_q resets to the clamp of a zero request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= CNT_W'(0);
      len_q       <= CNT_W'(1);
      out_len_q   <= CNT_W'(0);
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      out_len_q   <= out_len_d;
      out_valid_q <= out_valid_d;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_lane
    accu_lane #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .accept (accept_s),
      .last   (last_pending_s),
      .din    (bus.din[k*IN_W +: IN_W]),
      .dout   (dout_s[k*OUT_W +: OUT_W])
    );
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_len   = out_len_q;
  assign bus.dout      = dout_s;

endmodule

// File: tb/tb_accu_window_unit.sv
// Directed self-checking bench for accu_window_unit with default parameters.
module tb_accu_window_unit;

  localparam int IN_W    = 32;
  localparam int CH      = 4;
  localparam int MAX_LEN = 64;
  localparam int OUT_W   = 38;
  localparam int CNT_W   = 7;

  logic clk;
  logic rst_n;
  logic clr;
  int   checks;
  int   errors;

  accu_window_unit_if #(.IN_W(IN_W), .CH(CH), .MAX_LEN(MAX_LEN)) bus ();

  accu_window_unit #(.IN_W(IN_W), .CH(CH), .MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < CH; k++) bus.din[k*IN_W +: IN_W] = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0;
    bus.win_len = 7'd4; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    set_all(0);
    cyc(); cyc();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid); end
    checks++; if (bus.dout !== '0) begin errors++; $display("FAIL reset_dout got %h exp 0", bus.dout); end
    checks++; if (bus.out_len !== 7'd0) begin errors++; $display("FAIL reset_out_len got %0d exp 0", bus.out_len); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", bus.in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %0b exp 1", bus.in_ready); end
  endtask

  task automatic test_window4();
    logic [OUT_W-1:0] got;
    bus.win_len = 7'd4; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    for (int k = 0; k < CH; k++) bus.din[k*IN_W +: IN_W] = k + 1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      checks++;
      if (bus.out_valid !== (i % 4 == 0)) begin errors++; $display("FAIL w4_valid step %0d got %0b", i, bus.out_valid); end
      if (i % 4 == 0) begin
        for (int k = 0; k < CH; k++) begin
          got = bus.dout[k*OUT_W +: OUT_W];
          checks++; if (got !== OUT_W'(4 * (k + 1))) begin errors++; $display("FAIL w4_lane%0d got %0d exp %0d", k, got, 4 * (k + 1)); end
        end
        checks++; if (bus.out_len !== 7'd4) begin errors++; $display("FAIL w4_len got %0d exp 4", bus.out_len); end
      end
    end
    bus.in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_no_wrap();
    logic [OUT_W-1:0] got;
    logic [OUT_W-1:0] exp_v;
    exp_v = 38'h3E80000000;
    bus.win_len = 7'd3; bus.in_valid = 1'b1;
    set_all(32'h80000000);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      checks++; if (bus.out_valid !== (i == 3)) begin errors++; $display("FAIL wrap_valid step %0d got %0b", i, bus.out_valid); end
    end
    for (int k = 0; k < CH; k++) begin
      got = bus.dout[k*OUT_W +: OUT_W];
      checks++; if (got !== exp_v) begin errors++; $display("FAIL wrap_lane%0d got %h exp %h", k, got, exp_v); end
    end
    bus.in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_backpressure();
    logic [OUT_W-1:0] got;
    bus.win_len = 7'd2; bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    set_all(1); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy1 got %0b exp 1", bus.in_ready); end
    cyc(); set_all(2); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy2 got %0b exp 1", bus.in_ready); end
    cyc(); set_all(3); #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_len !== 7'd2) begin errors++; $display("FAIL bp_first got v=%0b len=%0d exp v=1 len=2", bus.out_valid, bus.out_len); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy3 got %0b exp 1", bus.in_ready); end
    cyc(); set_all(4); #1;
    for (int i = 0; i < 3; i++) begin
      got = bus.dout[0 +: OUT_W];
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall%0d in_ready got %0b exp 0", i, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1 || got !== OUT_W'(3)) begin errors++; $display("FAIL bp_hold%0d got v=%0b d=%0d exp v=1 d=3", i, bus.out_valid, got); end
      if (i < 2) cyc();
    end
    bus.out_ready = 1'b1; #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %0b exp 1", bus.in_ready); end
    cyc(); bus.in_valid = 1'b0;
    for (int k = 0; k < CH; k++) begin
      got = bus.dout[k*OUT_W +: OUT_W];
      checks++; if (got !== OUT_W'(7)) begin errors++; $display("FAIL bp_second_lane%0d got %0d exp 7", k, got); end
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_no_bubble got %0b exp 1", bus.out_valid); end
    cyc();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b exp 0", bus.out_valid); end
  endtask

  task automatic test_passthrough();
    logic signed [OUT_W-1:0] exp_v;
    logic [OUT_W-1:0]        got;
    int                      v;
    bus.win_len = 7'd1; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < CH; k++) bus.din[k*IN_W +: IN_W] = (k == 0) ? -(i + 1) : i * 10 + k;
      cyc();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_len !== 7'd1) begin errors++; $display("FAIL pt_valid step %0d got v=%0b len=%0d", i, bus.out_valid, bus.out_len); end
      for (int k = 0; k < CH; k++) begin
        v = (k == 0) ? -(i + 1) : i * 10 + k;
        exp_v = v;
        got = bus.dout[k*OUT_W +: OUT_W];
        checks++; if (got !== exp_v) begin errors++; $display("FAIL pt_lane%0d step %0d got %h exp %h", k, i, got, exp_v); end
      end
    end
    bus.in_valid = 1'b0;
    cyc();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL pt_drain got %0b exp 0", bus.out_valid); end
  endtask

  task automatic test_clamp();
    logic [OUT_W-1:0] got;
    bus.win_len = 7'd0; bus.in_valid = 1'b1; set_all(9);
    cyc(); bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_len !== 7'd1) begin errors++; $display("FAIL clamp0 got v=%0b len=%0d exp v=1 len=1", bus.out_valid, bus.out_len); end
    cyc();
    bus.win_len = 7'd100; bus.in_valid = 1'b1; set_all(1);
    for (int i = 1; i <= MAX_LEN; i++) begin
      cyc();
      if (i == MAX_LEN - 1) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clamp_max_early got %0b exp 0", bus.out_valid); end
      end
    end
    bus.in_valid = 1'b0;
    got = bus.dout[3*OUT_W +: OUT_W];
    checks++; if (bus.out_valid !== 1'b1 || bus.out_len !== 7'd64 || got !== OUT_W'(64)) begin errors++; $display("FAIL clamp_max got v=%0b len=%0d d=%0d exp v=1 len=64 d=64", bus.out_valid, bus.out_len, got); end
    cyc();
  endtask

  task automatic test_async_reset();
    logic [OUT_W-1:0] got;
    bus.win_len = 7'd4; bus.out_ready = 1'b1; bus.in_valid = 1'b1; set_all(1);
    cyc(); cyc();
    rst_n = 1'b0; #2;
    checks++; if (bus.dout !== '0 || bus.out_len !== 7'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_outputs got v=%0b len=%0d d=%h exp all 0", bus.out_valid, bus.out_len, bus.dout); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready got %0b exp 1", bus.in_ready); end
    #2; rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++; if (bus.out_valid !== (i == 4)) begin errors++; $display("FAIL arst_valid step %0d got %0b", i, bus.out_valid); end
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < CH; k++) begin
      got = bus.dout[k*OUT_W +: OUT_W];
      checks++; if (got !== OUT_W'(4)) begin errors++; $display("FAIL arst_lane%0d got %0d exp 4", k, got); end
    end
    cyc();
  endtask

  task automatic test_len_change_clr();
    logic [OUT_W-1:0] got;
    bus.win_len = 7'd4; bus.out_ready = 1'b1; bus.in_valid = 1'b1; set_all(1);
    cyc();
    bus.win_len = 7'd2;
    for (int i = 2; i <= 3; i++) begin
      cyc();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lc_early_close step %0d got %0b exp 0", i, bus.out_valid); end
    end
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lc_clr_discard got %0b exp 0", bus.out_valid); end
    set_all(5);
    cyc();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lc_new_first got %0b exp 0", bus.out_valid); end
    cyc();
    bus.in_valid = 1'b0;
    got = bus.dout[2*OUT_W +: OUT_W];
    checks++; if (bus.out_valid !== 1'b1 || bus.out_len !== 7'd2 || got !== OUT_W'(10)) begin errors++; $display("FAIL lc_new_window got v=%0b len=%0d d=%0d exp v=1 len=2 d=10", bus.out_valid, bus.out_len, got); end
    cyc();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_window4();
    test_no_wrap();
    test_backpressure();
    test_passthrough();
    test_clamp();
    test_async_reset();
    test_len_change_clr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/accu_window_unit.md
ACCU_WINDOW_UNIT -- requirements
Module: accu_window_unit

Interface
REQ-001 SHALL take parameter IN_W, default 32, as the signed per-channel sample width.
REQ-002 SHALL take parameter CH, default 4, as the number of parallel channels.
REQ-003 SHALL take parameter MAX_LEN, default 64, as the maximum window length in samples; MAX_LEN is at least 2.
REQ-004 SHALL derive CNT_W = clog2(MAX_LEN+1) and OUT_W = IN_W + clog2(MAX_LEN) as localparams.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 clr  input  1  synchronous clear, active high.
REQ-008 win_len  input  CNT_W  requested window length, sampled at window start.
REQ-009 in_valid  input  1  din holds a sample for every channel.
REQ-010 in_ready  output  1  block accepts din this cycle.
REQ-011 din  input  CH*IN_W  signed samples; channel k at bits [k*IN_W +: IN_W].
REQ-012 out_valid  output  1  dout holds a completed window sum.
REQ-013 out_ready  input  1  consumer takes dout this cycle.
REQ-014 dout  output  CH*OUT_W  signed window sums; channel k at bits [k*OUT_W +: OUT_W].
REQ-015 out_len  output  CNT_W  window length that produced dout.

Function
REQ-016 SHALL accept a sample only when in_valid and in_ready are both 1 (accept).
REQ-017 SHALL, on accept, add the sign-extended din lane to each channel accumulator; the accumulators are OUT_W bits wide and cannot overflow for any legal window.
REQ-018 SHALL latch the effective length len_q at the first accept of each window, and after reset or clr: win_len 0 -> 1, win_len > MAX_LEN -> MAX_LEN.
REQ-019 SHALL keep a sample counter in 0..len_q-1; the accept with counter == len_q-1 is the last sample of the window.
REQ-020 SHALL, on the last-sample accept, load acc+din into the output register, load len_q into out_len, clear the accumulators and counter, and assert out_valid on the next cycle (latency 1).
REQ-021 SHALL hold dout, out_len and out_valid stable until out_valid and out_ready are both 1.
REQ-022 SHALL drive in_ready = NOT(last_pending AND out_valid AND NOT out_ready), where last_pending = (counter == len_q-1); non-last samples are never stalled.
REQ-023 SHALL, when a pop and a new result occur in the same cycle, load the new result with out_valid staying 1 and no bubble.
REQ-024 SHALL treat len_q = 1 as a pass-through in which every accept produces a result.
REQ-025 SHALL give clr priority over accept and pop: clear accumulators, counter and out_valid, and re-latch the length on the next accept.
REQ-026 SHALL ignore din whenever there is no accept.

Reset
REQ-027 SHALL, while rst_n is 0, force accumulators, counter, dout and out_len to 0, out_valid to 0 and len_q to the clamped win_len (0 -> 1).
REQ-028 SHALL drive in_ready to 1 during and immediately after reset.
REQ-029 SHALL discard any window in progress when reset is asserted mid-window; the first accept after reset starts a new window.

Structure
REQ-030 SHALL place the default IN_W, CH and MAX_LEN values and a constant clog2 function in shared package accu_pkg.
REQ-031 SHALL instantiate sub-module accu_lane (one signed accumulator plus its output register) CH times via generate; counter, length and handshake logic live in accu_window_unit.

Verification
REQ-032 Test 1: win_len=4, CH=4, continuous valid, channel k = k+1 -> out_valid after each 4th accept, dout lanes 4, 8, 12, 16, out_len=4.
REQ-033 Test 2: win_len=3, samples -2^31, -2^31, -2^31 on all lanes -> dout lanes = -3*2^31 with no wrap (OUT_W=38).
REQ-034 Test 3: win_len=2 with out_ready held 0 for 5 cycles -> in_ready drops only on the last sample, first result held, no sample lost, sums are exact after release.
REQ-035 Test 4: win_len=1, out_ready=1 -> out_valid stays 1 continuously, dout equals din delayed one cycle.
REQ-036 Test 5: rst_n pulsed low after 2 of 4 samples -> all outputs are 0 asynchronously, and the next window of 4 ones sums to exactly 4.
REQ-037 Test 6: win_len changed from 4 to 2 mid-window, plus clr in the same cycle as the last-sample accept -> current window closes at 4 samples, clr discards the result, the next window uses length 2.
